vga_raster_gen: RTL and testbench
=================================

// Module: vga_raster_gen
// PURPOSE
//  Parametrised VGA raster engine: timing generation, pixel-RAM fetch with configurable read latency, and
//  output alignment. Generalises the fixed 640x480 controller. Adds programmable porches, sync polarity,
//  colour depth, a frame-synchronous horizontal-scroll register (valid/ready), and frame/line strobes.
//  Sits between the game-state pixel RAM and the board VGA DAC pins.
// PARAMETERS
//  H_SYNC   96   hsync pulse width, pixels          | H_BP 48 / H_ACT 640 / H_FP 16 : porches/active, pixels
//  V_SYNC   2    vsync pulse width, lines           | V_BP 33 / V_ACT 480 / V_FP 10 : porches/active, lines
//  HS_POL   0    0 = hs low during sync pulse; 1 = high  | VS_POL 0 : same for vs
//  COLOR_W  4    bits per colour channel
//  RD_LAT   1    pixel-RAM read latency, cycles; legal range 0..4
// PORTS
//  vga_clk       in   1          pixel clock (25 MHz at defaults)
//  clrn          in   1          asynchronous, active-low reset
//  pix_data      in   3*COLOR_W  {b,g,r} from pixel RAM, valid RD_LAT cycles after rd_en
//  cfg_valid     in   1          scroll update offered
//  cfg_scroll_x  in   10         new horizontal scroll, pixels
//  cfg_ready     out  1          scroll update accepted when cfg_valid && cfg_ready
//  rd_en         out  1          pixel-RAM read strobe, active high
//  row_addr      out  9          pixel-RAM row, 0..V_ACT-1
//  col_addr      out  10         pixel-RAM column (scrolled), 0..H_ACT-1
//  r, g, b       out  COLOR_W    colour outputs; forced 0 outside active video
//  hs, vs        out  1          sync outputs; polarity per HS_POL / VS_POL
//  de            out  1          display enable, aligned with r/g/b
//  frame_start   out  1          one-cycle pulse, h_cnt==0 && v_cnt==0
//  line_start    out  1          one-cycle pulse, h_cnt==0
// BEHAVIOUR
//  - Counters: h_cnt 0..H_TOT-1 (H_TOT = H_SYNC+H_BP+H_ACT+H_FP). v_cnt advances when h_cnt wraps and
//    itself wraps at V_TOT-1. Region order: sync, back porch, active, front porch.
//    Active columns: H_SYNC+H_BP .. H_SYNC+H_BP+H_ACT-1; active lines likewise.
//  - Stage n: counters decoded. Stage n+1: rd_en, row_addr, col_addr registered.
//    Stage n+1+RD_LAT: pix_data sampled. Stage n+2+RD_LAT: r/g/b/hs/vs/de registered.
//    hs, vs and de are delayed so all four are mutually aligned.
//  - col_addr = (h_act_idx + scroll_x) with wrap: subtract H_ACT when the sum >= H_ACT.
//    row_addr = v_act_idx. Both are 0 when rd_en = 0.
//  - Scroll handshake: a one-entry shadow register with a pending flag.
//    cfg_ready = !pending && !frame_start_next, so there is never an accept in the cycle the shadow is applied.
//    Accept stores min(cfg_scroll_x, H_ACT-1) in the shadow and sets pending.
//    At frame_start, if pending: scroll_x <= shadow and pending clears. scroll_x never changes mid-frame.
//  - Reset (async, any cycle, including mid-frame): h_cnt=v_cnt=0, scroll_x=0, pending=0, delay pipes cleared.
//    Outputs at reset: rd_en=0, row/col_addr=0, r=g=b=0, de=0, frame_start=line_start=0, cfg_ready=0.
//    hs = vs = inactive level (!HS_POL, !VS_POL) from reset.
//  - After reset release, the first frame_start pulse is on the first clock edge; timing then runs free.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: a test_en input (1 bit) is added.
//    While test_en=1, r/g/b show 8 vertical colour bars of H_ACT/8 pixels each: bar k gives
//    r={COLOR_W{k[0]}}, g={COLOR_W{k[1]}}, b={COLOR_W{k[2]}}; pix_data is ignored and rd_en is held 0.
//    test_en is sampled only at frame_start.
//  Undefined: no test_en port; r/g/b always come from pix_data.
// STRUCTURE
//  vga_pkg: H_/V_ default timing constants, rgb_t packed struct {b,g,r}, the active-index function.
//  Sub-module vga_delay_line #(W, DEPTH): reset-cleared shift register used for hs/vs/de alignment.
// TESTING
//  1 Defaults, run 2 frames -> frame_start period 420000 cycles; hs low for 96 of every 800; vs low lines 0-1.
//  2 RD_LAT=3, pix_data = f(row,col) model RAM -> first de at h_cnt 144+2+3 = 149 on line 35;
//    pixel (0,0) data appears on r/g/b in that cycle; 640 de cycles per line.
//  3 cfg_scroll_x=600 accepted mid-frame -> unchanged this frame; next frame col_addr sequence 600..639,0..599.
//  4 cfg_valid held across frame_start -> no accept that cycle; cfg_scroll_x=1000 -> stored 639.
//  5 clrn pulsed at v_cnt=200, h_cnt=400 -> all outputs at reset values in the same cycle; restart at frame_start.
//  6 VGA_TEST_PATTERN_EN, test_en=1 -> cols 0-79 black, 80-159 red, ..., 560-639 white; rd_en=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, pixel word layout,
// run-state encoding and the active-region index helper.
package vga_pkg;

  localparam int unsigned H_SYNC_DEF  = 96;
  localparam int unsigned H_BP_DEF    = 48;
  localparam int unsigned H_ACT_DEF   = 640;
  localparam int unsigned H_FP_DEF    = 16;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned V_BP_DEF    = 33;
  localparam int unsigned V_ACT_DEF   = 480;
  localparam int unsigned V_FP_DEF    = 10;
  localparam int unsigned COLOR_W_DEF = 4;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] b;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] r;
  } rgb_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_t;

  // Offset of a counter value into the active region that begins at 'start'.
  function automatic int unsigned act_idx(input int unsigned cnt, input int unsigned start);
    return cnt - start;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Reset-cleared shift register; DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         vga_clk,
  input  logic         clrn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stages [DEPTH];

      always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
          for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
          stages[0] <= d;
          for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign q = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_raster_gen.sv
// Parametrised VGA raster engine: timing, pixel-RAM fetch, output alignment, scroll register.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_en input selecting 8 colour bars.
module vga_raster_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned H_ACT   = H_ACT_DEF,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF,
  parameter int unsigned V_BP    = V_BP_DEF,
  parameter int unsigned V_ACT   = V_ACT_DEF,
  parameter int unsigned V_FP    = V_FP_DEF,
  parameter bit          HS_POL  = 1'b0,
  parameter bit          VS_POL  = 1'b0,
  parameter int unsigned COLOR_W = COLOR_W_DEF,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                 vga_clk,
  input  logic                 clrn,
  input  logic [3*COLOR_W-1:0] pix_data,
  input  logic                 cfg_valid,
  input  logic [9:0]           cfg_scroll_x,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_en,
`endif
  output logic                 cfg_ready,
  output logic                 rd_en,
  output logic [8:0]           row_addr,
  output logic [9:0]           col_addr,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 hs,
  output logic                 vs,
  output logic                 de,
  output logic                 frame_start,
  output logic                 line_start
);

  localparam int unsigned H_TOT    = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOT    = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned H_ASTART = H_SYNC + H_BP;
  localparam int unsigned V_ASTART = V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOT);
  localparam int unsigned VW       = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
  localparam logic [HW-1:0] H_A0     = HW'(H_ASTART);
  localparam logic [HW-1:0] H_A1     = HW'(H_ASTART + H_ACT);
  localparam logic [VW-1:0] V_A0     = VW'(V_ASTART);
  localparam logic [VW-1:0] V_A1     = VW'(V_ASTART + V_ACT);
  localparam logic [9:0]    SCR_MAX  = 10'(H_ACT - 1);
  localparam logic [10:0]   H_ACT_W  = 11'(H_ACT);

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned PW = 7;
`else
  localparam int unsigned PW = 3;
`endif

  run_state_t    state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, fs_next, running;

  assign h_last  = (h_cnt == H_LAST);
  assign v_last  = (v_cnt == V_LAST);
  assign running = (state == ST_RUN);
  // The idle state holds the counters at 0,0 for one edge so the first pulse follows release.
  assign fs_next = (state == ST_IDLE) || (h_last && v_last);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state       <= ST_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state       <= ST_RUN;
          frame_start <= 1'b1;
          line_start  <= 1'b1;
        end
        ST_RUN: begin
          h_cnt <= h_last ? '0 : h_cnt + 1'b1;
          if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
          frame_start <= h_last && v_last;
          line_start  <= h_last;
        end
      endcase
    end
  end

  logic [9:0] scroll_x, shadow;
  logic       pending;

  assign cfg_ready = !pending && !fs_next;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      scroll_x <= '0;
      shadow   <= '0;
      pending  <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      shadow  <= (cfg_scroll_x > SCR_MAX) ? SCR_MAX : cfg_scroll_x;
      pending <= 1'b1;
    end else if (fs_next && pending) begin
      scroll_x <= shadow;
      pending  <= 1'b0;
    end
  end

  logic        act, hs_a, vs_a, rd_go;
  logic [9:0]  h_idx, col_scr;
  logic [8:0]  v_idx;
  logic [10:0] col_sum;

  assign hs_a    = running && (h_cnt < H_SYNC_E);
  assign vs_a    = running && (v_cnt < V_SYNC_E);
  assign act     = running && (h_cnt >= H_A0) && (h_cnt < H_A1) && (v_cnt >= V_A0) && (v_cnt < V_A1);
  assign h_idx   = 10'(act_idx(32'(h_cnt), H_ASTART));
  assign v_idx   = 9'(act_idx(32'(v_cnt), V_ASTART));
  assign col_sum = {1'b0, h_idx} + {1'b0, scroll_x};
  assign col_scr = (col_sum >= H_ACT_W) ? 10'(col_sum - H_ACT_W) : col_sum[9:0];

  logic [PW-1:0] pipe_d, pipe_s1, pipe_q;

`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode;
  logic [2:0] bar;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn)        test_mode <= 1'b0;
    else if (fs_next) test_mode <= test_en;
  end

  assign bar    = 3'(32'(h_idx) / (H_ACT / 8));
  assign rd_go  = act && !test_mode;
  assign pipe_d = {bar, test_mode, vs_a, hs_a, act};
`else
  assign rd_go  = act;
  assign pipe_d = {vs_a, hs_a, act};
`endif

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rd_en    <= 1'b0;
      row_addr <= '0;
      col_addr <= '0;
      pipe_s1  <= '0;
    end else begin
      rd_en    <= rd_go;
      row_addr <= rd_go ? v_idx : '0;
      col_addr <= rd_go ? col_scr : '0;
      pipe_s1  <= pipe_d;
    end
  end

  // Timing bits wait out the RAM latency so they meet pix_data at the output register.
  vga_delay_line #(
    .W     (PW),
    .DEPTH (RD_LAT)
  ) u_align (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .d       (pipe_s1),
    .q       (pipe_q)
  );

  logic [3*COLOR_W-1:0] pix_sel;

  always_comb begin
    pix_sel = '0;
    if (pipe_q[0]) begin
`ifdef VGA_TEST_PATTERN_EN
      if (pipe_q[3])
        pix_sel = {{COLOR_W{pipe_q[6]}}, {COLOR_W{pipe_q[5]}}, {COLOR_W{pipe_q[4]}}};
      else
        pix_sel = pix_data;
`else
      pix_sel = pix_data;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r  <= '0;
      g  <= '0;
      b  <= '0;
      de <= 1'b0;
      hs <= !HS_POL;
      vs <= !VS_POL;
    end else begin
      r  <= pix_sel[COLOR_W-1:0];
      g  <= pix_sel[2*COLOR_W-1:COLOR_W];
      b  <= pix_sel[3*COLOR_W-1:2*COLOR_W];
      de <= pipe_q[0];
      hs <= pipe_q[1] ? HS_POL : !HS_POL;
      vs <= pipe_q[2] ? VS_POL : !VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_raster_gen.sv
// Randomised bench for vga_raster_gen on a reduced raster, checked against a
// cycle-indexed arithmetic model of position, scroll and pixel-RAM contents.
module tb_vga_raster_gen;

  localparam int H_SYNC = 8,  H_BP = 6, H_ACT = 40, H_FP = 4;
  localparam int V_SYNC = 2,  V_BP = 3, V_ACT = 12, V_FP = 2;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b1;
  localparam int CW = 4, RD_LAT = 3;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int F_TOT = H_TOT * V_TOT;
  localparam int HA0 = H_SYNC + H_BP, VA0 = V_SYNC + V_BP;

  logic          vga_clk = 1'b0;
  logic          clrn;
  logic [3*CW-1:0] pix_data;
  logic          cfg_valid;
  logic [9:0]    cfg_scroll_x;
  logic          cfg_ready, rd_en, hs, vs, de, frame_start, line_start;
  logic [8:0]    row_addr;
  logic [9:0]    col_addr;
  logic [CW-1:0] r, g, b;
`ifdef VGA_TEST_PATTERN_EN
  logic          test_en = 1'b0;
`endif

  vga_raster_gen #(
    .H_SYNC (H_SYNC), .H_BP (H_BP), .H_ACT (H_ACT), .H_FP (H_FP),
    .V_SYNC (V_SYNC), .V_BP (V_BP), .V_ACT (V_ACT), .V_FP (V_FP),
    .HS_POL (HS_POL), .VS_POL (VS_POL), .COLOR_W (CW), .RD_LAT (RD_LAT)
  ) dut (
    .vga_clk      (vga_clk),
    .clrn         (clrn),
    .pix_data     (pix_data),
    .cfg_valid    (cfg_valid),
    .cfg_scroll_x (cfg_scroll_x),
`ifdef VGA_TEST_PATTERN_EN
    .test_en      (test_en),
`endif
    .cfg_ready    (cfg_ready),
    .rd_en        (rd_en),
    .row_addr     (row_addr),
    .col_addr     (col_addr),
    .r            (r),
    .g            (g),
    .b            (b),
    .hs           (hs),
    .vs           (vs),
    .de           (de),
    .frame_start  (frame_start),
    .line_start   (line_start)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct { bit act; bit hsa; bit vsa; int row; int col; } dec_t;
  typedef struct { bit en; int row; int col; } req_t;

  dec_t hist[$];
  req_t reqs[$];
  int   k, seg;
  int   scroll, shadow, acc_val;
  bit   pending, acc_prev, sent30;
  int   n_cmp = 0, n_err = 0;
  int   fs_n, fs1, fs2, de_cnt, hs_cnt, first_de_h;
  bit   de_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s seg %0d cycle %0d: got 0x%0h expected 0x%0h", tag, seg, k, got, exp);
    end
  endtask

  function automatic logic [11:0] ram_word(input int row, input int col);
    return 12'(row * 64 + col + 1);
  endfunction

  function automatic dec_t entry(input int j);
    dec_t z;
    z.act = 0; z.hsa = 0; z.vsa = 0; z.row = 0; z.col = 0;
    if (j < 1) return z;
    return hist[j-1];
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, "_rd"},  32'(rd_en), 0);
    check_eq({tag, "_row"}, 32'(row_addr), 0);
    check_eq({tag, "_col"}, 32'(col_addr), 0);
    check_eq({tag, "_rgb"}, 32'({b, g, r}), 0);
    check_eq({tag, "_de"},  32'(de), 0);
    check_eq({tag, "_hs"},  32'(hs), 32'(!HS_POL));
    check_eq({tag, "_vs"},  32'(vs), 32'(!VS_POL));
    check_eq({tag, "_fs"},  32'(frame_start), 0);
    check_eq({tag, "_ls"},  32'(line_start), 0);
    check_eq({tag, "_rdy"}, 32'(cfg_ready), 0);
  endtask

  task automatic reset_model();
    k = 0; hist.delete(); reqs.delete();
    scroll = 0; shadow = 0; pending = 0; acc_prev = 0;
  endtask

  task automatic step();
    dec_t d, e1, eo;
    req_t q;
    int h, v, j, x;
    bit exp_ready, val;
    @(posedge vga_clk); #1;
    k++;
    if (acc_prev) begin shadow = acc_val; pending = 1; acc_prev = 0; end
    h = (k - 1) % H_TOT;
    v = ((k - 1) / H_TOT) % V_TOT;
    if (h == 0 && v == 0 && pending) begin scroll = shadow; pending = 0; end
    d.act = (h >= HA0 && h < HA0 + H_ACT && v >= VA0 && v < VA0 + V_ACT);
    d.hsa = (h < H_SYNC);
    d.vsa = (v < V_SYNC);
    d.row = d.act ? v - VA0 : 0;
    d.col = d.act ? (h - HA0 + scroll) % H_ACT : 0;
    hist.push_back(d);
    e1 = entry(k - 1);
    eo = entry(k - 2 - RD_LAT);
    exp_ready = !pending && ((k % F_TOT) != 0);

    check_eq("fs",  32'(frame_start), 32'(h == 0 && v == 0));
    check_eq("ls",  32'(line_start), 32'(h == 0));
    check_eq("rd",  32'(rd_en), 32'(e1.act));
    check_eq("row", 32'(row_addr), 32'(e1.row));
    check_eq("col", 32'(col_addr), 32'(e1.col));
    check_eq("de",  32'(de), 32'(eo.act));
    check_eq("hs",  32'(hs), 32'(eo.hsa ? HS_POL : !HS_POL));
    check_eq("vs",  32'(vs), 32'(eo.vsa ? VS_POL : !VS_POL));
    check_eq("rgb", 32'({b, g, r}), eo.act ? 32'(ram_word(eo.row, eo.col)) : 0);
    check_eq("rdy", 32'(cfg_ready), 32'(exp_ready));

    if (seg == 0) begin
      if (frame_start === 1'b1) begin
        if (fs_n == 0) fs1 = k; else if (fs_n == 1) fs2 = k;
        fs_n++;
      end
      if (k <= F_TOT) begin
        de_cnt += (de === 1'b1) ? 1 : 0;
        hs_cnt += (hs === HS_POL) ? 1 : 0;
      end
      if (!de_seen && de === 1'b1) begin de_seen = 1; first_de_h = h; end
    end

    // Pixel RAM answers RD_LAT cycles after the strobe; other cycles carry junk.
    q.en = rd_en; q.row = int'(row_addr); q.col = int'(col_addr);
    reqs.push_back(q);
    j = k - RD_LAT;
    if (j >= 1 && reqs[j-1].en) pix_data = ram_word(reqs[j-1].row, reqs[j-1].col);
    else                        pix_data = 12'($urandom);

    val = 0; x = 0;
    if (seg == 0 && k >= 300 && !sent30) begin
      val = 1; x = 30;
      if (exp_ready) sent30 = 1;
    end else if (seg == 0 && k >= F_TOT - 8 && k <= F_TOT + 8) begin
      val = 1; x = 1000;
    end else if ((seg == 0 && k > 2 * F_TOT + 50) || (seg == 1 && k > 20)) begin
      val = ($urandom_range(0, 63) == 0);
      x = $urandom_range(0, 1023);
    end
    cfg_valid = val;
    cfg_scroll_x = 10'(x);
    if (val && exp_ready) begin
      acc_prev = 1;
      acc_val = (x > H_ACT - 1) ? H_ACT - 1 : x;
    end
  endtask

  initial begin
    clrn = 1'b0; cfg_valid = 1'b0; cfg_scroll_x = '0; pix_data = '0;
    seg = 0; sent30 = 0; fs_n = 0; fs1 = 0; fs2 = 0;
    de_cnt = 0; hs_cnt = 0; first_de_h = -1; de_seen = 0;
    reset_model();
    #12;
    check_reset("rst_init");
    @(negedge vga_clk);
    clrn = 1'b1;

    repeat (3 * F_TOT + 8 * H_TOT + 20 + 1) step();

    check_eq("fs_period",  32'(fs2 - fs1), 32'(F_TOT));
    check_eq("de_count",   32'(de_cnt), 32'(H_ACT * V_ACT));
    check_eq("hs_count",   32'(hs_cnt), 32'(H_SYNC * V_TOT));
    check_eq("first_de_h", 32'(first_de_h), 32'(HA0 + 2 + RD_LAT));

    // Asynchronous reset in the middle of an active line.
    #2 clrn = 1'b0;
    cfg_valid = 1'b0;
    #1 check_reset("rst_mid");
    @(posedge vga_clk); #1;
    check_reset("rst_hold");
    @(negedge vga_clk);
    clrn = 1'b1;
    seg = 1;
    reset_model();
    repeat (2 * F_TOT + 10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
